sub_64bit: RTL and testbench
============================

// Module: sub_64bit
// PURPOSE
//   64-bit two's-complement subtractor with borrow-in and signed-overflow flag.
//   Forms the SUB datapath of the Y86 pipeline ALU (subq / cmp-style flag generation).
//   Arithmetic core is a combinational ripple chain (a + ~b + ~cin); outputs are registered.
// PARAMETERS
//   none (width fixed at 64)
// PORTS
//   clk       input   1   system clock; all state updates on rising edge
//   rst_n     input   1   synchronous reset, active-low
//   a         input   64  minuend, signed two's complement
//   b         input   64  subtrahend, signed two's complement
//   cin       input   1   borrow-in; 1 subtracts one extra
//   result    output  64  registered a - b - cin, modulo 2^64
//   overflow  output  1   registered signed-overflow flag for this result
// BEHAVIOUR
//   - Single clock clk; reset is synchronous and active-low (rst_n).
//   - Rising edge with rst_n=0: result <= 64'd0, overflow <= 1'b0; inputs ignored that cycle.
//   - Rising edge with rst_n=1: result <= a - b - cin, overflow <= ovf(a,b,sum).
//   - Latency: 1 clock; new operands every cycle; no handshake, no stall.
//   - Datapath: sum = a + ~b + carry0, where carry0 = ~cin.
//     Implement as 64 chained full-adder cells with per-bit generate/propagate.
//   - Result wraps modulo 2^64; carry-out of bit 63 is discarded and not exported.
//   - overflow = (a[63] != b[63]) & (sum[63] != a[63]); independent of carry-out.
//   - b = 0, cin = 0: result equals a, overflow 0.
//   - a = b, cin = 0: result 0, overflow 0.
//   - b = 64'h8000_0000_0000_0000 is handled by the same formula, with no special case.
//   - Reset asserted mid-stream: reset values win that edge.
//     The next edge with rst_n=1 registers the current inputs.
//   - Outputs hold between edges; asynchronous input glitches never reach result/overflow.
//   - No X propagation from reset: both outputs are defined from the first reset edge.
// TESTING
//   (cin=0 unless stated; check outputs 1 clk after apply; hold rst_n=0 2 clks first -> result=0, ovf=0)
//   a=64'h000F, b=-4 (64'hFFFF_FFFF_FFFF_FFFC) -> result=64'h13, overflow=0
//   a=b=64'hFFFF_FFFF_FFFF_FFFC -> result=0, overflow=0
//   a=64'h08C9_A97C_A7A2_975A, b=64'hABEA_B2B5_ADAA_AAA9
//     -> result=64'h5CDE_F6C6_F9F7_ECB1, overflow=0
//   a=64'h7FFF_FFFF_FFFF_FFFF, b=-1 -> result=64'h8000_0000_0000_0000, overflow=1
//   a=64'h8000_0000_0000_0000, b=1 -> result=64'h7FFF_FFFF_FFFF_FFFF, overflow=1
//   a=10, b=3, cin=1 -> result=6, overflow=0
//   a=64'hC4F5_4004_A1EB_66BE, b=0 -> result=a, overflow=0
//   Reset mid-stream: drive rst_n=0 for one edge -> outputs 0; next edge -> registered difference.
//   Randomized check: 10k signed pairs plus random cin vs a-b-cin reference model, incl. ovf formula.

Source files
------------

// File: rtl/sub_64bit_if.sv
// Operand/result bundle for the 64-bit subtractor: operands in, registered difference and flag out.
interface sub_64bit_if;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [63:0] result;
  logic        overflow;

  modport master (output a, output b, output cin, input result, input overflow);
  modport slave  (input a, input b, input cin, output result, output overflow);
endinterface

// File: rtl/sub_64bit.sv
// 64-bit two's-complement subtractor (a - b - cin) for the ALU SUB path.
// Ripple chain of full-adder cells computes a + ~b + ~cin; result and overflow are registered.
module sub_64bit (
  input  logic        clk,
  input  logic        rst_n,
  sub_64bit_if.slave  bus
);

  logic [63:0] b_inv;
  logic [63:0] gen;
  logic [63:0] prop;
  logic [63:0] carry;
  logic [63:0] sum;
  logic        ovf;

  assign b_inv    = ~bus.b;
  assign carry[0] = ~bus.cin;

  // Carry out of bit 63 is never formed: the result wraps and overflow uses sign bits only.
  genvar i;
  generate
    for (i = 0; i < 64; i++) begin : g_fa
      assign gen[i]  = bus.a[i] & b_inv[i];
      assign prop[i] = bus.a[i] ^ b_inv[i];
      assign sum[i]  = prop[i] ^ carry[i];
      if (i < 63) begin : g_carry
        assign carry[i+1] = gen[i] | (prop[i] & carry[i]);
      end
    end
  endgenerate

  assign ovf = (bus.a[63] != bus.b[63]) & (sum[63] != bus.a[63]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.result   <= 64'd0;
      bus.overflow <= 1'b0;
    end else begin
      bus.result   <= sum;
      bus.overflow <= ovf;
    end
  end

endmodule

// File: tb/tb_sub_64bit.sv
// Bench for sub_64bit: directed vector table, reset/hold sequences, and randomized model check.
module tb_sub_64bit;

  logic clk = 1'b0;
  logic rst_n;

  sub_64bit_if bus ();

  sub_64bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] r;
    logic        o;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [63:0] er, input logic eo);
    tests++;
    if (bus.result !== er || bus.overflow !== eo) begin
      fails++;
      $display("FAIL %s: got result=%h overflow=%b, expected result=%h overflow=%b",
               nm, bus.result, bus.overflow, er, eo);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns after the next rising edge.
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic cin);
    @(negedge clk);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    @(posedge clk);
    #1;
  endtask

  // Reference: exact signed integer difference; overflow means it does not fit in 64 signed bits.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                output logic [63:0] r, output logic o);
    logic signed [65:0] d;
    logic signed [65:0] max_s;
    logic signed [65:0] min_s;
    max_s = (66'sd1 <<< 63) - 66'sd1;
    min_s = -(66'sd1 <<< 63);
    d = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, cin});
    r = d[63:0];
    o = (d > max_s) || (d < min_s);
  endfunction

  initial begin
    logic [63:0] ra, rb, er;
    logic        rc, eo;

    vecs[0] = '{64'h000F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h13, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0, 1'b0};
    vecs[2] = '{64'h08C9_A97C_A7A2_975A, 64'hABEA_B2B5_ADAA_AAA9, 1'b0, 64'h5CDE_F6C6_F9F7_ECB1, 1'b0};
    vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[5] = '{64'd10, 64'd3, 1'b1, 64'd6, 1'b0};
    vecs[6] = '{64'hC4F5_4004_A1EB_66BE, 64'd0, 1'b0, 64'hC4F5_4004_A1EB_66BE, 1'b0};
    vecs[7] = '{64'd0, 64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b1};
    vecs[8] = '{64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};

    // Reset with live, nonzero inputs: they must be ignored.
    rst_n   = 1'b0;
    bus.a   = 64'h1234_5678_9ABC_DEF0;
    bus.b   = 64'h0000_0000_0000_0001;
    bus.cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 64'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("vec%0d", i), vecs[i].r, vecs[i].o);
    end

    // Outputs hold between edges even when inputs move.
    drive(64'd100, 64'd1, 1'b0);
    bus.a = 64'hFFFF_0000_FFFF_0000;
    bus.b = 64'h0000_FFFF_0000_FFFF;
    #2;
    check("hold", 64'd99, 1'b0);

    // Reset mid-stream wins its edge; the following edge registers the current inputs.
    @(negedge clk);
    rst_n   = 1'b0;
    bus.a   = 64'h7FFF_FFFF_FFFF_FFFF;
    bus.b   = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.cin = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid", 64'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset", 64'h8000_0000_0000_0000, 1'b1);

    for (int n = 0; n < 10000; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      case ($urandom_range(0, 7))
        0: ra = {1'b0, {63{1'b1}}};
        1: ra = {1'b1, 63'd0};
        2: rb = {1'b1, 63'd0};
        3: rb = ra;
        default: ;
      endcase
      model(ra, rb, rc, er, eo);
      drive(ra, rb, rc);
      check($sformatf("rand%0d", n), er, eo);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
